// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end feeding the IF/ID register
// Single outstanding request to a variable-latency instruction memory, with stall hold and redirect flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] PCp4_out,
  output logic        if_valid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target    = redirect_target & ~32'h3;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // HOLD issues the next fetch in the same cycle the held instruction is consumed.
  always_comb begin
    imem_req = 1'b0;
    if (rst_n && !redirect) begin
      if (state == S_FETCH)
        imem_req = 1'b1;
      else if (state == S_HOLD && !stall)
        imem_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_FETCH;
      pc              <= RESET_PC & ~32'h3;
      kill            <= 1'b0;
      if_valid        <= 1'b0;
      instruction_out <= 32'h0;
      PCp4_out        <= 32'h0;
    end else if (redirect) begin
      pc       <= target;
      if_valid <= 1'b0;
      // A request already in flight must have its response swallowed.
      if (state == S_WAIT && !imem_rvalid) begin
        kill  <= 1'b1;
        state <= S_WAIT;
      end else begin
        kill  <= 1'b0;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_FETCH;
            end else begin
              instruction_out <= imem_rdata;
              PCp4_out        <= pc_plus4;
              pc              <= pc_plus4;
              if_valid        <= 1'b1;
              state           <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid <= 1'b0;
            state    <= S_WAIT;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] PCp4_out;
  logic        if_valid;

  logic        m_rvalid = 1'b0;
  logic        inj_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          mem_lat = 1;
  int          cnt = 0;
  logic        req_seen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] paddr = 32'h0;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = 32'h0;
  logic [31:0] w_instr;
  logic [31:0] w_pcp4;
  logic        w_valid;

  int n_assert = 0;
  int n_fail = 0;

  assign imem_rvalid = m_rvalid | inj_rvalid;
  assign imem_rdata  = m_rdata;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_out(instruction_out), .PCp4_out(PCp4_out), .if_valid(if_valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
    .redirect_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instruction_out(w_instr), .PCp4_out(w_pcp4), .if_valid(w_valid)
  );

  // Memory returns the address as data, L cycles after the request cycle.
  always @(negedge clk) begin
    req_seen = imem_req;
    req_addr = imem_addr;
  end

  always begin
    @(posedge clk);
    #1;
    m_rvalid = 1'b0;
    if (req_seen) begin
      cnt   = mem_lat;
      paddr = req_addr;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = paddr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (if_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'h0, if_valid}, 32'h1);
  endtask

  initial begin
    tick();
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pcp4", PCp4_out, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);

    // L=1 streaming, one instruction every 2 cycles
    rst_n = 1'b1;
    #1;
    chk("c0_req", {31'h0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    tick();
    chk("c1_req", {31'h0, imem_req}, 32'h0);
    chk("c1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    chk("c2_valid", {31'h0, if_valid}, 32'h1);
    chk("c2_instr", instruction_out, 32'h0);
    chk("c2_pcp4", PCp4_out, 32'h4);
    chk("c2_addr", imem_addr, 32'h4);
    chk("c2_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("c3_valid", {31'h0, if_valid}, 32'h0);
    tick();
    chk("c4_instr", instruction_out, 32'h4);
    chk("c4_pcp4", PCp4_out, 32'h8);
    chk("c4_addr", imem_addr, 32'h8);
    tick();
    stall = 1'b1;
    tick();
    chk("c6_valid", {31'h0, if_valid}, 32'h1);
    chk("c6_instr", instruction_out, 32'h8);
    chk("c6_pcp4", PCp4_out, 32'hC);

    // stall held in HOLD
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'h0, imem_req}, 32'h0);
      chk("stall_valid", {31'h0, if_valid}, 32'h1);
      chk("stall_instr", instruction_out, 32'h8);
      if (i < 2) tick();
    end
    stall = 1'b0;
    #1;
    chk("unstall_req", {31'h0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr, 32'hC);
    tick();
    chk("c9_valid", {31'h0, if_valid}, 32'h0);
    tick();
    chk("c10_instr", instruction_out, 32'hC);
    chk("c10_pcp4", PCp4_out, 32'h10);

    // redirect while waiting on an L=3 response
    mem_lat = 3;
    tick();
    redirect = 1'b1;
    redirect_target = 32'h100;
    #1;
    chk("rdw_req", {31'h0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rdw_valid0", {31'h0, if_valid}, 32'h0);
    chk("rdw_req0", {31'h0, imem_req}, 32'h0);
    tick();
    chk("rdw_stale_rv", {31'h0, imem_rvalid}, 32'h1);
    chk("rdw_valid1", {31'h0, if_valid}, 32'h0);
    tick();
    chk("rdw_valid2", {31'h0, if_valid}, 32'h0);
    chk("rdw_req2", {31'h0, imem_req}, 32'h1);
    chk("rdw_addr2", imem_addr, 32'h100);
    wait_valid(10);
    chk("rdw_instr", instruction_out, 32'h100);
    chk("rdw_pcp4", PCp4_out, 32'h104);

    // redirect and stall together in HOLD, misaligned target
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h203;
    #1;
    chk("rs_req", {31'h0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0;
    mem_lat = 1;
    #1;
    chk("rs_valid", {31'h0, if_valid}, 32'h0);
    chk("rs_req1", {31'h0, imem_req}, 32'h1);
    chk("rs_addr", imem_addr, 32'h200);
    stall = 1'b0;
    wait_valid(5);
    chk("rs_instr", instruction_out, 32'h200);
    chk("rs_pcp4", PCp4_out, 32'h204);

    // redirect coincident with the response
    mem_lat = 2;
    tick();
    chk("rr_valid0", {31'h0, if_valid}, 32'h0);
    tick();
    chk("rr_rvalid", {31'h0, imem_rvalid}, 32'h1);
    redirect = 1'b1;
    redirect_target = 32'h300;
    #1;
    chk("rr_req", {31'h0, imem_req}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rr_valid1", {31'h0, if_valid}, 32'h0);
    chk("rr_req1", {31'h0, imem_req}, 32'h1);
    chk("rr_addr", imem_addr, 32'h300);
    wait_valid(10);
    chk("rr_instr", instruction_out, 32'h300);
    chk("rr_pcp4", PCp4_out, 32'h304);

    // reset during WAIT with a stale response around release
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'h0, if_valid}, 32'h0);
    chk("mr_instr", instruction_out, 32'h0);
    chk("mr_pcp4", PCp4_out, 32'h0);
    chk("mr_req", {31'h0, imem_req}, 32'h0);
    tick();
    rst_n = 1'b1;
    inj_rvalid = 1'b1;
    #1;
    chk("mr_req1", {31'h0, imem_req}, 32'h1);
    chk("mr_addr1", imem_addr, 32'h0);
    tick();
    inj_rvalid = 1'b0;
    #1;
    chk("mr_stale_valid", {31'h0, if_valid}, 32'h0);
    chk("mr_stale_req", {31'h0, imem_req}, 32'h0);
    wait_valid(10);
    chk("mr_instr1", instruction_out, 32'h0);
    chk("mr_pcp4_1", PCp4_out, 32'h4);

    // PC wrap on the second instance
    rst_n = 1'b0;
    #1;
    chk("w_rst_valid", {31'h0, w_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("w_req0", {31'h0, w_req}, 32'h1);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    tick();
    w_rvalid = 1'b1;
    w_rdata = 32'hDEAD_BEEF;
    #1;
    chk("w_req1", {31'h0, w_req}, 32'h0);
    tick();
    w_rvalid = 1'b0;
    #1;
    chk("w_valid", {31'h0, w_valid}, 32'h1);
    chk("w_instr", w_instr, 32'hDEAD_BEEF);
    chk("w_pcp4", w_pcp4, 32'h0);
    chk("w_req2", {31'h0, w_req}, 32'h1);
    chk("w_addr2", w_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
